// File: rtl/mtime_timer.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime with prescaler, mtimecmp and msip.
// Exposes mtime directly and raises timer/software interrupt lines for the core.
module mtime_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_wr_en,
  input  logic        i_rd_en,
  output logic [31:0] o_rd_data,
  output logic [63:0] o_mtime,
  output logic        o_timer_irq,
  output logic        o_sw_irq
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] ps_cnt;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        hit;
  logic [2:0]  offset;
  logic        wr;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign hit              = (i_addr[31:5] == BASE_ADDR[31:5]);
  assign offset           = i_addr[4:2];
  assign wr               = hit && (i_byte_wr_en != 4'b0000);
  assign tick             = (ps_cnt == PS_LAST);
  assign unused_addr_bits = ^i_addr[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Read mux sees register values from the start of the cycle, so a read
  // colliding with a write returns the old contents.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    rd_word = '0;
    case (offset)
      3'd0: rd_word = mtime[31:0];
      3'd1: rd_word = mtime[63:32];
      3'd2: rd_word = mtimecmp[31:0];
      3'd3: rd_word = mtimecmp[63:32];
      3'd4: rd_word = {31'b0, msip};
      default: rd_word = '0;
    endcase
  end

  // A software write to either half of mtime wins over the tick increment.
  always_comb begin
    mtime_nxt = mtime;
    if (wr && offset == 3'd0)
      mtime_nxt[31:0] = merge_bytes(mtime[31:0], i_wr_data, i_byte_wr_en);
    else if (wr && offset == 3'd1)
      mtime_nxt[63:32] = merge_bytes(mtime[63:32], i_wr_data, i_byte_wr_en);
    else if (tick)
      mtime_nxt = mtime + 64'd1;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (i_rst) begin
      ps_cnt      <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      msip        <= 1'b0;
      o_rd_data   <= '0;
      o_timer_irq <= 1'b0;
    end else begin
      ps_cnt      <= tick ? 16'd0 : ps_cnt + 16'd1;
      mtime       <= mtime_nxt;
      o_timer_irq <= (mtime >= mtimecmp);
      if (wr && offset == 3'd2)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], i_wr_data, i_byte_wr_en);
      if (wr && offset == 3'd3)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], i_wr_data, i_byte_wr_en);
      if (wr && offset == 3'd4 && i_byte_wr_en[0])
        msip <= i_wr_data[0];
      if (i_rd_en)
        o_rd_data <= hit ? rd_word : 32'd0;
    end
  end

  assign o_mtime  = mtime;
  assign o_sw_irq = msip;

endmodule

// File: tb/tb_mtime_timer.sv
// Directed bench for mtime_timer: two instances (PRESCALE=4 and 1) share one bus;
// expected values go into a scoreboard queue and are popped when the output is sampled.
module tb_mtime_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  be;
  logic        rd_en;

  logic [31:0] rd4, rd1;
  logic [63:0] m4, m1;
  logic        tirq4, tirq1, sirq4, sirq1;

  always #5 clk = ~clk;

  mtime_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wr_data(wr_data),
    .i_byte_wr_en(be), .i_rd_en(rd_en), .o_rd_data(rd4), .o_mtime(m4),
    .o_timer_irq(tirq4), .o_sw_irq(sirq4)
  );

  mtime_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wr_data(wr_data),
    .i_byte_wr_en(be), .i_rd_en(rd_en), .o_rd_data(rd1), .o_mtime(m1),
    .o_timer_irq(tirq1), .o_sw_irq(sirq1)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] m);
    addr    = BASE + {27'd0, off, 2'b00};
    wr_data = d;
    be      = m;
    step();
    be      = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a);
    addr  = a;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = BASE; wr_data = '0; be = '0; rd_en = 1'b0;
    step();
    step();

    push_exp("rst_mtime", 64'd0);           check(m1);
    push_exp("rst_rd_data", 64'd0);         check({32'd0, rd1});
    push_exp("rst_timer_irq", 64'd0);       check({63'd0, tirq1});
    push_exp("rst_sw_irq", 64'd0);          check({63'd0, sirq1});
    rst = 1'b0;

    // Prescale 4: mtime holds 0 for four cycles, then steps every fourth.
    for (int k = 1; k <= 12; k++) begin
      step();
      push_exp($sformatf("ps4_tick_%0d", k), 64'(k / 4));
      check(m4);
    end

    // 64-bit carry and wrap.
    bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    push_exp("mtime_all_ones", 64'hFFFF_FFFF_FFFF_FFFF); check(m1);
    step();
    push_exp("mtime_wrap", 64'd0);          check(m1);
    bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    bus_write(3'd1, 32'h0000_0000, 4'hF);
    push_exp("mtime_lo_max", 64'h0000_0000_FFFF_FFFF); check(m1);
    step();
    push_exp("mtime_carry", 64'h0000_0001_0000_0000); check(m1);

    // Timer interrupt against mtimecmp = 10.
    bus_write(3'd1, 32'd0, 4'hF);
    bus_write(3'd0, 32'd0, 4'hF);
    push_exp("mtime_cleared", 64'd0);       check(m1);
    bus_write(3'd2, 32'd10, 4'hF);
    bus_write(3'd3, 32'd0, 4'hF);
    for (int i = 0; i < 50 && m1 != 64'd10; i++) step();
    push_exp("mtime_reach_10", 64'd10);     check(m1);
    push_exp("irq_lag_at_10", 64'd0);       check({63'd0, tirq1});
    step();
    push_exp("irq_rise", 64'd1);            check({63'd0, tirq1});
    bus_write(3'd3, 32'd1, 4'hF);
    push_exp("irq_hold_on_write", 64'd1);   check({63'd0, tirq1});
    step();
    push_exp("irq_clear", 64'd0);           check({63'd0, tirq1});

    // Byte-masked write, then read-before-write on a colliding access.
    bus_write(3'd2, 32'h1122_3344, 4'hF);
    bus_write(3'd2, 32'hAABB_CCDD, 4'b0101);
    bus_read(BASE + 32'h8);
    push_exp("byte_mask_read", 64'h11BB_33DD); check({32'd0, rd1});
    addr = BASE + 32'h8; wr_data = 32'h5566_7788; be = 4'hF; rd_en = 1'b1;
    step();
    be = 4'b0000; rd_en = 1'b0;
    push_exp("rd_before_wr", 64'h11BB_33DD); check({32'd0, rd1});
    bus_read(BASE + 32'h8);
    push_exp("rd_after_wr", 64'h5566_7788); check({32'd0, rd1});
    step();
    push_exp("rd_data_hold", 64'h5566_7788); check({32'd0, rd1});

    // Decode: unmapped offset and out-of-window address read zero.
    bus_read(BASE + 32'h14);
    push_exp("rd_offset5", 64'd0);          check({32'd0, rd1});
    bus_read(BASE + 32'hC);
    push_exp("rd_cmp_hi", 64'd1);           check({32'd0, rd1});
    bus_read(BASE + 32'h20);
    push_exp("rd_miss", 64'd0);             check({32'd0, rd1});

    // Software interrupt.
    bus_write(3'd4, 32'hFFFF_FFFF, 4'hF);
    push_exp("sw_irq_set", 64'd1);          check({63'd0, sirq1});
    bus_read(BASE + 32'h10);
    push_exp("rd_msip", 64'd1);             check({32'd0, rd1});

    // Arm the timer irq, then reset mid-count.
    bus_write(3'd2, 32'd0, 4'hF);
    bus_write(3'd3, 32'd0, 4'hF);
    step();
    push_exp("irq_pre_reset", 64'd1);       check({63'd0, tirq1});
    step();
    rst = 1'b1;
    step();
    push_exp("mid_rst_mtime1", 64'd0);      check(m1);
    push_exp("mid_rst_mtime4", 64'd0);      check(m4);
    push_exp("mid_rst_rd_data", 64'd0);     check({32'd0, rd1});
    push_exp("mid_rst_timer_irq", 64'd0);   check({63'd0, tirq1});
    push_exp("mid_rst_sw_irq", 64'd0);      check({63'd0, sirq1});
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      push_exp($sformatf("resume_tick_%0d", k), 64'(k / 4));
      check(m4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtime_timer.md
MTIME_TIMER -- requirements
Module: mtime_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000, 32-byte-aligned base of the register window.
REQ-002 SHALL have parameter PRESCALE, default 1, i_clk cycles per mtime tick; legal range 1..65535.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_addr  input  32  CPU data-memory byte address.
REQ-006 SHALL have port i_wr_data  input  32  write data.
REQ-007 SHALL have port i_byte_wr_en  input  4  per-byte write enable; bit n qualifies i_wr_data[8n+7:8n].
REQ-008 SHALL have port i_rd_en  input  1  read request.
REQ-009 SHALL have port o_rd_data  output  32  read data, valid one cycle after i_rd_en.
REQ-010 SHALL have port o_mtime  output  64  current mtime for CPU i_mtime.
REQ-011 SHALL have port o_timer_irq  output  1  machine timer interrupt pending.
REQ-012 SHALL have port o_sw_irq  output  1  machine software interrupt pending.

Function
REQ-013 SHALL decode a hit when i_addr[31:5] == BASE_ADDR[31:5]; word offset = i_addr[4:2]; i_addr[1:0] ignored.
REQ-014 SHALL map offsets: 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 msip (bit 0 only, bits 31:1 read 0); offsets 5-7 read 0, writes ignored.
REQ-015 SHALL apply writes only on hit with nonzero i_byte_wr_en, updating only enabled bytes of the addressed word.
REQ-016 SHALL keep a prescale counter counting 0..PRESCALE-1, wrapping to 0; a tick occurs in the cycle the counter equals PRESCALE-1.
REQ-017 SHALL increment mtime by 1 as a full 64-bit add on each tick (carry from bit 31 into bit 32 same cycle; 0xFFFF_FFFF_FFFF_FFFF wraps to 0).
REQ-018 SHALL, when a write to offset 0 or 1 coincides with a tick, apply the write and suppress that increment; the unwritten word holds its value; prescale counter continues unaffected.
REQ-019 SHALL register o_rd_data: cycle N with i_rd_en and hit -> cycle N+1 presents the addressed register's value as held at start of cycle N (read-before-write).
REQ-020 SHALL drive o_rd_data = 0 in the cycle after i_rd_en without hit, and hold its previous value when i_rd_en was low.
REQ-021 SHALL drive o_mtime directly from the mtime register (no added latency).
REQ-022 SHALL register o_timer_irq = (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on register values at start of each cycle (one-cycle lag after any mtime/mtimecmp change).
REQ-023 SHALL drive o_sw_irq directly from msip[0]; it changes the cycle after the write.
REQ-024 SHALL accept simultaneous i_rd_en and write to the same offset, returning old value per REQ-019.

Reset
REQ-025 SHALL, on i_rst high at a rising edge, set mtime=0, prescale counter=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, o_rd_data=0, o_timer_irq=0; o_sw_irq therefore 0.
REQ-026 SHALL give reset priority over any concurrent write, read or tick, including mid-count resets; counting resumes from 0 the first cycle i_rst is low.

Verification
REQ-027 SHALL verify reset/tick: PRESCALE=4, release reset -> o_mtime 0 for 4 cycles, then 1, reaching 3 after 12 cycles post-reset.
REQ-028 SHALL verify carry/wrap: byte_wr_en=4'hF writes 0xFFFF_FFFF to offsets 0 and 1, PRESCALE=1 -> o_mtime 0xFFFF_FFFF_FFFF_FFFF then 0 next cycle; writing lo=0xFFFF_FFFF, hi=0 -> 0x1_0000_0000 after one tick.
REQ-029 SHALL verify timer irq: mtimecmp={0,10}, mtime=0, PRESCALE=1 -> o_timer_irq rises the cycle after o_mtime reads 10; writing mtimecmp hi=1 clears it one cycle later.
REQ-030 SHALL verify byte-masked write: mtimecmp lo=0x1122_3344, write 0xAABB_CCDD with byte_wr_en=4'b0101 -> readback 0x11BB_33DD one cycle after i_rd_en.
REQ-031 SHALL verify decode: read offset 5 and address BASE_ADDR+0x20 -> o_rd_data 0; write msip=1 -> o_sw_irq 1 next cycle; assert i_rst mid-count -> all outputs to REQ-025 values next cycle.
